tcounter_param: RTL

TCOUNTER_PARAM -- requirements
Module: tcounter_param

---
 rtl/tcounter_param_if.sv | 13 +
 rtl/tcounter_param.sv | 54 +++++
 2 files changed

// File: rtl/tcounter_param_if.sv
// tcounter_param_if: control and status bundle for tcounter_param.
interface tcounter_param_if #(
  parameter int WIDTH = 4
);
  logic             enable;
  logic             up;
  logic             load;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] q;
  logic             tc;
  modport master (output enable, output up, output load, output d, input q, input tc);
  modport slave  (input enable, input up, input load, input d, output q, output tc);
endinterface

// File: rtl/tcounter_param.sv
// tcounter_param: modulo up/down counter with load, terminal-count pulse and optional prescaler (TCNT_PRESCALE_EN).
module tcounter_param #(
  parameter int     WIDTH    = 4,
  parameter longint MODULUS  = 16,
  parameter int     PRESCALE = 4
) (
  input  logic            clk,
  input  logic            reset,
  tcounter_param_if.slave bus
);
  localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 1);
  logic [WIDTH-1:0] q_q, q_d;
  logic             tc_q, tc_d;
  logic             tick;
  logic             step;
  logic             wrap;
`ifdef TCNT_PRESCALE_EN
  localparam int PW = $clog2(PRESCALE);
  localparam logic [PW-1:0] PLAST = PW'(PRESCALE - 1);
  logic [PW-1:0] ps_q, ps_d;
  // prescaler clears on load, advances on enabled cycles and wraps at PRESCALE-1
  always_comb begin
    tick = ps_q == PLAST;
    ps_d = bus.load ? '0 : !bus.enable ? ps_q : tick ? '0 : ps_q + PW'(1);
  end
  // prescaler register
  always_ff @(posedge clk or posedge reset)
    if (reset) ps_q <= '0;
    else       ps_q <= ps_d;
`else
  assign tick = 1'b1;
`endif
  // next count: load saturates at MAX, steps wrap at the modulus ends
  always_comb begin
    step = !bus.load && bus.enable && tick;
    wrap = bus.up ? (q_q == MAX) : (q_q == '0);
    q_d  = bus.load ? ((bus.d > MAX) ? MAX : bus.d)
         : !step    ? q_q
         : bus.up   ? (wrap ? '0 : q_q + WIDTH'(1))
         :            (wrap ? MAX : q_q - WIDTH'(1));
    tc_d = step && wrap;
  end
  // count and terminal-count registers
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      q_q  <= '0;
      tc_q <= 1'b0;
    end else begin
      q_q  <= q_d;
      tc_q <= tc_d;
    end
  assign bus.q  = q_q;
  assign bus.tc = tc_q;
endmodule
